// File: rtl/mult9x9_accum.sv
// Group accumulator behind a MULT9X9: sums LEN products and publishes each group
// sum on ACC with a one-cycle ACC_VALID strobe. Define MULT9X9_ACCUM_SAT_EN for saturating adds.
module mult9x9_accum #(
  parameter int ACC_W  = 24,
  parameter int LEN    = 4,
  parameter int SIGNED = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic             CLR,
  input  logic             IN_VALID,
  input  logic [17:0]      Z,
  output logic [ACC_W-1:0] ACC,
  output logic             ACC_VALID,
  output logic             OVF,
  output logic             BUSY
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic [ACC_W-1:0] z_ext;
  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] wrap;
  logic             add_ovf;
  logic [ACC_W-1:0] add_res;

  assign z_ext = (SIGNED != 0) ? ACC_W'($signed(Z)) : ACC_W'(Z);
  assign raw   = {1'b0, sum_q} + {1'b0, z_ext};
  assign wrap  = raw[ACC_W-1:0];

  // Signed overflow: like-signed operands whose result changes sign.
  assign add_ovf = (SIGNED != 0)
                 ? ((sum_q[ACC_W-1] == z_ext[ACC_W-1]) && (wrap[ACC_W-1] != sum_q[ACC_W-1]))
                 : raw[ACC_W];

`ifdef MULT9X9_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W-1:0] sat_val;

  // On signed overflow both operands share a sign, so the operand sign picks the rail.
  assign sat_val = (SIGNED != 0) ? (sum_q[ACC_W-1] ? SMIN : SMAX) : UMAX;
  assign add_res = add_ovf ? sat_val : wrap;
`else
  assign add_res = wrap;
`endif

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    vld_d     = 1'b0;
    if (ENA) begin
      if (CLR) begin
        state_d   = IDLE;
        sum_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
      end else if (IN_VALID) begin
        if (cnt_q == LAST) begin
          acc_d     = add_res;
          ovf_d     = ovf_acc_q | add_ovf;
          vld_d     = 1'b1;
          state_d   = IDLE;
          sum_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end else begin
          sum_d     = add_res;
          cnt_d     = cnt_q + 1'b1;
          ovf_acc_d = ovf_acc_q | add_ovf;
          state_d   = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
    end
  end

  assign ACC       = acc_q;
  assign ACC_VALID = vld_q;
  assign OVF       = ovf_q;
  assign BUSY      = (state_q == ACCUM);

endmodule
